// File: rtl/btn_pkg.sv
// ----------------------------------------------------------------------------
// btn_pkg
// Shared constants and helpers for the push-button conditioner.
//   BTN_DEBOUNCE_10MS_12MHZ : default debounce window (10 ms at 12 MHz)
//   BTN_LONG_2S_12MHZ       : default long-press hold time (2 s at 12 MHz)
//   cnt_width()             : bit width of a counter that must reach max_count
// ----------------------------------------------------------------------------
package btn_pkg;

  localparam int BTN_DEBOUNCE_10MS_12MHZ = 120000;
  localparam int BTN_LONG_2S_12MHZ       = 24000000;

  // Width needed to hold the values 0..max_count. Never returns less than 1
  // so a degenerate count still produces a legal vector.
  function automatic int cnt_width(input int max_count);
    if (max_count < 1) begin
      return 1;
    end
    return $clog2(max_count + 1);
  endfunction

endpackage : btn_pkg

// File: rtl/button_debouncer_if.sv
// ----------------------------------------------------------------------------
// button_debouncer_if
// Bundles the raw button pins and the conditioned outputs of button_debouncer.
// Optional feature macro: BTN_LONG_PRESS_EN adds the btn_long vector.
//
// Signals (N_BTN bits each, bit i = channel i):
//   btn_in      : raw asynchronous pins (driven by the board / bench)
//   btn_state   : debounced level, 1 = pressed
//   btn_press   : one-cycle pulse when a press is accepted
//   btn_release : one-cycle pulse when a release is accepted
//   btn_long    : one-cycle pulse once per press after the long hold time
//
// Signalling: there is no valid/ready handshake. btn_state is a level that is
// always valid after reset; btn_press, btn_release and btn_long are events that
// are high for exactly one hwclk cycle and must be consumed in that cycle.
//
// Modports:
//   slave  : the debouncer (reads btn_in, drives the conditioned outputs)
//   master : the pin source / consumer side (drives btn_in, reads outputs)
// ----------------------------------------------------------------------------
interface button_debouncer_if #(
  parameter int N_BTN = 4
);

  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_state;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
`ifdef BTN_LONG_PRESS_EN
  logic [N_BTN-1:0] btn_long;
`endif

`ifdef BTN_LONG_PRESS_EN
  modport slave (
    input  btn_in,
    output btn_state,
    output btn_press,
    output btn_release,
    output btn_long
  );

  modport master (
    output btn_in,
    input  btn_state,
    input  btn_press,
    input  btn_release,
    input  btn_long
  );
`else
  modport slave (
    input  btn_in,
    output btn_state,
    output btn_press,
    output btn_release
  );

  modport master (
    output btn_in,
    input  btn_state,
    input  btn_press,
    input  btn_release
  );
`endif

endinterface : button_debouncer_if

// File: rtl/button_debounce_ch.sv
// ----------------------------------------------------------------------------
// button_debounce_ch
// One button channel: polarity normalise, 2-flop synchroniser, debounce
// counter, and (optionally) long-press counter. All outputs are registered.
// Optional feature macro: BTN_LONG_PRESS_EN adds lcnt and the btn_long output.
//
// Ports:
//   hwclk       : in  system clock
//   rst_n       : in  asynchronous active-low reset
//   btn_raw     : in  raw asynchronous button pin
//   btn_state   : out debounced level, 1 = pressed
//   btn_press   : out one-cycle pulse on accepted 0->1
//   btn_release : out one-cycle pulse on accepted 1->0
//   btn_long    : out one-cycle pulse once per press after LONG_CYCLES held
// ----------------------------------------------------------------------------
module button_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_10MS_12MHZ,
`ifdef BTN_LONG_PRESS_EN
  parameter int LONG_CYCLES     = BTN_LONG_2S_12MHZ,
`endif
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic hwclk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_state,
  output logic btn_press,
`ifdef BTN_LONG_PRESS_EN
  output logic btn_release,
  output logic btn_long
`else
  output logic btn_release
`endif
);

  localparam int            DW    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          raw;
  logic          s1;
  logic          s2;
  logic          state_q;
  logic          press_q;
  logic          release_q;
  logic [DW-1:0] dcnt;

  // Normalise so that 1 always means "pressed" from here on.
  assign raw = btn_raw ^ ACTIVE_LOW;

  // s1 may go metastable; only s2 is ever looked at by the filter.
  // The filter needs DEBOUNCE_CYCLES consecutive disagreements between s2
  // and the accepted level; a single agreeing cycle restarts the window.
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      state_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      dcnt      <= '0;
    end else begin
      s1        <= raw;
      s2        <= s1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      if (s2 == state_q) begin
        dcnt <= '0;
      end else if (dcnt == DLAST) begin
        state_q   <= s2;
        dcnt      <= '0;
        press_q   <= s2;
        release_q <= ~s2;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  assign btn_state   = state_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

`ifdef BTN_LONG_PRESS_EN
  localparam int            LW    = cnt_width(LONG_CYCLES);
  localparam logic [LW-1:0] LMAX  = LW'(LONG_CYCLES);
  localparam logic [LW-1:0] LLAST = LW'(LONG_CYCLES - 1);

  logic [LW-1:0] lcnt;
  logic          long_q;

  // lcnt follows the registered level, so it clears the cycle after the
  // level falls and starts counting the cycle after it rises. Saturating at
  // LMAX is what limits btn_long to one pulse per press.
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt   <= '0;
      long_q <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (!state_q) begin
        lcnt <= '0;
      end else if (lcnt < LMAX) begin
        lcnt <= lcnt + 1'b1;
        if (lcnt == LLAST) begin
          long_q <= 1'b1;
        end
      end
    end
  end

  assign btn_long = long_q;
`endif

endmodule : button_debounce_ch

// File: rtl/button_debouncer.sv
// ----------------------------------------------------------------------------
// button_debouncer
// Multi-channel push-button conditioner. Each raw pin is synchronised to
// hwclk, filtered against contact bounce and presented as a clean level plus
// single-cycle press / release (and optional long-press) pulses. Channels are
// fully independent.
// Optional feature macro: BTN_LONG_PRESS_EN enables long-press detection and
// the btn_long vector; without it LONG_CYCLES is accepted but has no effect.
//
// Parameters:
//   N_BTN           : number of channels
//   DEBOUNCE_CYCLES : consecutive stable cycles to accept a change (>= 1)
//   LONG_CYCLES     : cycles a press must persist before btn_long (>= 1)
//   ACTIVE_LOW      : 1 = pin reads 0 when pressed
//
// Ports:
//   hwclk : in  system clock
//   rst_n : in  asynchronous active-low reset
//   btn   : button_debouncer_if.slave (btn_in in; btn_state, btn_press,
//           btn_release, btn_long out)
// ----------------------------------------------------------------------------
module button_debouncer
  import btn_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_10MS_12MHZ,
  parameter int LONG_CYCLES     = BTN_LONG_2S_12MHZ,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic                     hwclk,
  input  logic                     rst_n,
  button_debouncer_if.slave        btn
);

  // Reject configurations whose counters would never fire.
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("button_debouncer: DEBOUNCE_CYCLES must be >= 1");
  end
  if (LONG_CYCLES < 1) begin : g_bad_long
    $error("button_debouncer: LONG_CYCLES must be >= 1");
  end

  logic [N_BTN-1:0] state_w;
  logic [N_BTN-1:0] press_w;
  logic [N_BTN-1:0] release_w;
`ifdef BTN_LONG_PRESS_EN
  logic [N_BTN-1:0] long_w;
`endif

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`ifdef BTN_LONG_PRESS_EN
      .LONG_CYCLES     (LONG_CYCLES),
`endif
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_ch (
      .hwclk       (hwclk),
      .rst_n       (rst_n),
      .btn_raw     (btn.btn_in[i]),
      .btn_state   (state_w[i]),
      .btn_press   (press_w[i]),
`ifdef BTN_LONG_PRESS_EN
      .btn_release (release_w[i]),
      .btn_long    (long_w[i])
`else
      .btn_release (release_w[i])
`endif
    );
  end

  assign btn.btn_state   = state_w;
  assign btn.btn_press   = press_w;
  assign btn.btn_release = release_w;
`ifdef BTN_LONG_PRESS_EN
  assign btn.btn_long    = long_w;
`endif

endmodule : button_debouncer

// File: doc/button_debouncer.md
# button_debouncer

Multi-channel push-button input conditioner for the board's user buttons: the input-side counterpart to the free-running-counter LED drivers. Each raw, asynchronous button pin is synchronized to `hwclk`, filtered against contact bounce, and presented as a clean level plus single-cycle press, release and optional long-press pulses. Downstream control logic consumes only these outputs and never samples raw pins.

## Interface
- `N_BTN`, 4: number of button channels.
- `DEBOUNCE_CYCLES`, 120000: consecutive stable cycles required to accept a level change (10 ms at 12 MHz); must be ≥1.
- `LONG_CYCLES`, 24000000: cycles a debounced press must persist before `btn_long` fires (2 s at 12 MHz); must be ≥1.
- `ACTIVE_LOW`, 0: 1 = raw pin reads 0 when pressed; inversion is applied before the synchronizer output is used.

Ports:
- `hwclk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `btn_in`, in, N_BTN: raw button pins, asynchronous.
- `btn_state`, out, N_BTN: debounced level, 1 = pressed.
- `btn_press`, out, N_BTN: 1-cycle pulse on accepted 0→1.
- `btn_release`, out, N_BTN: 1-cycle pulse on accepted 1→0.
- `btn_long`, out, N_BTN: 1-cycle pulse once per press after LONG_CYCLES held. Present only with `BTN_LONG_PRESS_EN`.

## Operation
- Per channel, fully independent; no cross-channel interaction.
- Polarity normalize: `raw = btn_in[i] ^ ACTIVE_LOW`.
- Synchronizer: 2 flops, `s1 <= raw`, `s2 <= s1`; reset value 0 (not pressed).
- Debounce counter `dcnt`, width `$clog2(DEBOUNCE_CYCLES+1)`:
  - `s2 == state`: `dcnt <= 0`.
  - `s2 != state` and `dcnt == DEBOUNCE_CYCLES-1`: `state <= s2`, `dcnt <= 0`, pulse press (s2=1) or release (s2=0).
  - otherwise: `dcnt <= dcnt + 1`.
  - Any single cycle of agreement during counting restarts the window (bounce rejection).
- Long-press counter `lcnt`, width `$clog2(LONG_CYCLES+1)`:
  - cleared to 0 whenever `state == 0`.
  - while `state == 1` and `lcnt < LONG_CYCLES`: increment; on the increment reaching LONG_CYCLES, pulse `btn_long`.
  - saturates at LONG_CYCLES; no repeat pulse until release then new press.
- Pulses are registered outputs, high exactly one cycle, never simultaneous press and release on one channel.

## Timing
- Reset (async assert, sync release OK): `s1`,`s2`,`state`,`dcnt`,`lcnt` = 0; all outputs 0.
- Latency: raw change settled before edge 0 → `s2` valid after edge 2 → `btn_state` and `btn_press`/`btn_release` update at edge 2+DEBOUNCE_CYCLES (the DEBOUNCE_CYCLES-th consecutive mismatching cycle).
- `btn_press` is high in the same cycle `btn_state` first reads 1; `btn_release` in the same cycle it first reads 0.
- `btn_long` high at edge LONG_CYCLES after the edge that set `btn_state`.
- Reset mid-press: button still held after `rst_n` rises → accepted as a fresh press after the full latency; no release pulse emitted for the aborted state.
- Release during long counting: `lcnt` clears on the cycle after `state` falls; no `btn_long`.

## Configuration
- `BTN_LONG_PRESS_EN` defined: `lcnt`, `btn_long` port and behaviour compiled in.
- Undefined: no `lcnt` logic, `btn_long` port absent; `LONG_CYCLES` parameter accepted and ignored.

## Structure
- Shared package `btn_pkg`: default constants `BTN_DEBOUNCE_10MS_12MHZ`, `BTN_LONG_2S_12MHZ`, and the `clog2`-based width helper.
- Sub-module `button_debounce_ch`: one channel (sync, `dcnt`, `lcnt`, pulses); top generates N_BTN instances and packs outputs.

## Test plan
Bench uses `DEBOUNCE_CYCLES=4`, `LONG_CYCLES=16`, `N_BTN=2`, `BTN_LONG_PRESS_EN` defined.
- Reset: hold `rst_n=0`, `btn_in=2'b11` → all outputs 0; release reset → `btn_state=11` with one `btn_press` pulse on each channel at edge 6 after release.
- Clean press: `btn_in[0]` 0→1 before edge 0 → `btn_state[0]`=1 and `btn_press[0]`=1 at edge 6 only; `btn_press[0]`=0 at edge 7.
- Bounce: toggle `btn_in[0]` 1,0,1,0,1 each cycle then hold 1 → no pulse during toggling; press accepted 6 cycles after final stable 1.
- Glitch: 3-cycle high pulse on idle channel → `btn_state` stays 0, no pulses.
- Long press: hold 30 cycles after acceptance → one `btn_long[0]` 16 cycles after `btn_press[0]`, none after; release → `btn_release[0]` 6 cycles later; press of 10 cycles gives no `btn_long`.
- `ACTIVE_LOW=1` rerun: `btn_in[1]` 1→0 → `btn_press[1]` at edge 6; channel 0 unaffected.
